// File: rtl/msk_aes_inv_mc_stream.sv
// Masked AES InvMixColumns streaming block.
// Each of the d Boolean shares of a 32-bit column is transformed on its own
// (InvMixColumns is linear over GF(2), so the XOR of the output shares is
// InvMixColumns of the unmasked column). No randomness is consumed.
// Elastic valid/ready pipeline with a 2-bit column index that marks the last
// column of each AES state on out_last.
// Build option: define MSK_INV_MC_TWO_STAGE_EN for a two-register pipeline
// (pre-multiply by circulant 05,00,04,00, then forward MixColumns); the
// default build uses a single register after the full InvMixColumns.
module msk_aes_inv_mc_stream #(
    parameter int d = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [32*d-1:0] in_col,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [32*d-1:0] out_col,
    output logic            out_last
);

    // GF(2^8) multiply by 2, reduction polynomial 0x11b
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Extract one share of a masked column; row k lands in [8k +: 8]
    function automatic logic [31:0] get_share(input logic [32*d-1:0] c, input int s);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 8; j++) begin
                w[8*k+j] = c[8*d*k + d*j + s];
            end
        end
        return w;
    endfunction

    // Insert one share word back into the interleaved column layout
    function automatic logic [32*d-1:0] put_share(input logic [32*d-1:0] c, input int s,
                                                  input logic [31:0] w);
        logic [32*d-1:0] r;
        r = c;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 8; j++) begin
                r[8*d*k + d*j + s] = w[8*k+j];
            end
        end
        return r;
    endfunction

`ifdef MSK_INV_MC_TWO_STAGE_EN

    // Circulant (05,00,04,00): u_r = 05*a_r ^ 04*a_{r+2}
    function automatic logic [31:0] premul_word(input logic [31:0] w);
        logic [31:0] r;
        logic [7:0]  a0;
        logic [7:0]  a2;
        logic [7:0]  a2x4;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            a0   = w[8*k +: 8];
            a2   = w[8*((k+2)%4) +: 8];
            a2x4 = xtime(xtime(a2));
            r[8*k +: 8] = xtime(xtime(a0)) ^ a0 ^ a2x4;
        end
        return r;
    endfunction

    // Forward MixColumns: v_r = 02*a_r ^ 03*a_{r+1} ^ a_{r+2} ^ a_{r+3}
    function automatic logic [31:0] mc_word(input logic [31:0] w);
        logic [31:0] r;
        logic [7:0]  a0;
        logic [7:0]  a1;
        logic [7:0]  a2;
        logic [7:0]  a3;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            a0 = w[8*k +: 8];
            a1 = w[8*((k+1)%4) +: 8];
            a2 = w[8*((k+2)%4) +: 8];
            a3 = w[8*((k+3)%4) +: 8];
            r[8*k +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        end
        return r;
    endfunction

    function automatic logic [32*d-1:0] premul_col(input logic [32*d-1:0] c);
        logic [32*d-1:0] r;
        r = '0;
        for (int s = 0; s < d; s++) begin
            r = put_share(r, s, premul_word(get_share(c, s)));
        end
        return r;
    endfunction

    function automatic logic [32*d-1:0] mc_col(input logic [32*d-1:0] c);
        logic [32*d-1:0] r;
        r = '0;
        for (int s = 0; s < d; s++) begin
            r = put_share(r, s, mc_word(get_share(c, s)));
        end
        return r;
    endfunction

`else

    // InvMixColumns: o_r = 0e*a_r ^ 0b*a_{r+1} ^ 0d*a_{r+2} ^ 09*a_{r+3}
    function automatic logic [31:0] inv_mc_word(input logic [31:0] w);
        logic [31:0] r;
        logic [7:0]  a [4];
        logic [7:0]  x2 [4];
        logic [7:0]  x4 [4];
        logic [7:0]  x8 [4];
        r = '0;
        for (int k = 0; k < 4; k++) begin
            a[k]  = w[8*k +: 8];
            x2[k] = xtime(a[k]);
            x4[k] = xtime(x2[k]);
            x8[k] = xtime(x4[k]);
        end
        for (int k = 0; k < 4; k++) begin
            r[8*k +: 8] = (x8[k] ^ x4[k] ^ x2[k])
                        ^ (x8[(k+1)%4] ^ x2[(k+1)%4] ^ a[(k+1)%4])
                        ^ (x8[(k+2)%4] ^ x4[(k+2)%4] ^ a[(k+2)%4])
                        ^ (x8[(k+3)%4] ^ a[(k+3)%4]);
        end
        return r;
    endfunction

    function automatic logic [32*d-1:0] inv_mc_col(input logic [32*d-1:0] c);
        logic [32*d-1:0] r;
        r = '0;
        for (int s = 0; s < d; s++) begin
            r = put_share(r, s, inv_mc_word(get_share(c, s)));
        end
        return r;
    endfunction

`endif

    logic       in_xfer;
    logic [1:0] col_cnt_q;
    logic [1:0] col_cnt_d;

    assign in_xfer = in_valid && in_ready;

    // Column index advances on every accepted column and wraps 3 -> 0
    always_comb begin
        col_cnt_d = col_cnt_q + {1'b0, in_xfer};
    end

    // Column index register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt_q <= 2'd0;
        end else begin
            col_cnt_q <= col_cnt_d;
        end
    end

`ifdef MSK_INV_MC_TWO_STAGE_EN

    logic            vld_p0_q;
    logic            vld_p0_d;
    logic            last_p0_q;
    logic            last_p0_d;
    logic [32*d-1:0] data_p0_q;
    logic [32*d-1:0] data_p0_d;
    logic            vld_p1_q;
    logic            vld_p1_d;
    logic            last_p1_q;
    logic            last_p1_d;
    logic [32*d-1:0] data_p1_q;
    logic [32*d-1:0] data_p1_d;
    logic            rdy_p1;
    logic            xfer_p0;

    assign rdy_p1   = !vld_p1_q || out_ready;
    assign in_ready = !vld_p0_q || rdy_p1;
    assign xfer_p0  = vld_p0_q && rdy_p1;

    // Next-state of both stages: a stage refills whenever its slot frees up
    always_comb begin
        vld_p0_d  = vld_p0_q;
        last_p0_d = last_p0_q;
        data_p0_d = data_p0_q;
        vld_p1_d  = vld_p1_q;
        last_p1_d = last_p1_q;
        data_p1_d = data_p1_q;
        if (in_ready) begin
            vld_p0_d = in_valid;
        end
        if (in_xfer) begin
            last_p0_d = (col_cnt_q == 2'd3);
            data_p0_d = premul_col(in_col);
        end
        if (rdy_p1) begin
            vld_p1_d = vld_p0_q;
        end
        if (xfer_p0) begin
            last_p1_d = last_p0_q;
            data_p1_d = mc_col(data_p0_q);
        end
    end

    // Stage valid/last flags, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0_q  <= 1'b0;
            last_p0_q <= 1'b0;
            vld_p1_q  <= 1'b0;
            last_p1_q <= 1'b0;
        end else begin
            vld_p0_q  <= vld_p0_d;
            last_p0_q <= last_p0_d;
            vld_p1_q  <= vld_p1_d;
            last_p1_q <= last_p1_d;
        end
    end

    // Stage data registers, written only on a load
    always_ff @(posedge clk) begin
        data_p0_q <= data_p0_d;
        data_p1_q <= data_p1_d;
    end

    assign out_valid = vld_p1_q;
    assign out_last  = vld_p1_q && last_p1_q;
    assign out_col   = vld_p1_q ? data_p1_q : '0;

`else

    logic            vld_p0_q;
    logic            vld_p0_d;
    logic            last_p0_q;
    logic            last_p0_d;
    logic [32*d-1:0] data_p0_q;
    logic [32*d-1:0] data_p0_d;

    assign in_ready = !vld_p0_q || out_ready;

    // Next-state of the single stage: full InvMixColumns before the register
    always_comb begin
        vld_p0_d  = vld_p0_q;
        last_p0_d = last_p0_q;
        data_p0_d = data_p0_q;
        if (in_ready) begin
            vld_p0_d = in_valid;
        end
        if (in_xfer) begin
            last_p0_d = (col_cnt_q == 2'd3);
            data_p0_d = inv_mc_col(in_col);
        end
    end

    // Stage valid/last flags, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0_q  <= 1'b0;
            last_p0_q <= 1'b0;
        end else begin
            vld_p0_q  <= vld_p0_d;
            last_p0_q <= last_p0_d;
        end
    end

    // Stage data register, written only on a load
    always_ff @(posedge clk) begin
        data_p0_q <= data_p0_d;
    end

    assign out_valid = vld_p0_q;
    assign out_last  = vld_p0_q && last_p0_q;
    assign out_col   = vld_p0_q ? data_p0_q : '0;

`endif

endmodule

// File: tb/tb_msk_aes_inv_mc_stream.sv
// Scoreboard bench for msk_aes_inv_mc_stream (d = 2).
// Share words are written MSB-first: row 0 is the top byte of each 32-bit word.
module tb_msk_aes_inv_mc_stream;
    localparam int D = 2;
    localparam int W = 32 * D;
`ifdef MSK_INV_MC_TWO_STAGE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_col;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_col;
    logic         out_last;

    msk_aes_inv_mc_stream #(.d(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_col    (in_col),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_col   (out_col),
        .out_last  (out_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [W-1:0] col;
        logic         last;
        logic         has_gold;
        logic [31:0]  gold;
        logic         chk_lat;
        int           cyc;
    } exp_t;

    exp_t        q[$];
    int          out_cyc_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          push_cnt = 0;
    int          idx = 0;
    int          send_waits = 0;
    logic        cur_has_gold = 1'b0;
    logic [31:0] cur_gold = '0;
    logic        cur_chk_lat = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    // Reference InvMixColumns on one unmasked word, matrix form
    function automatic logic [31:0] ref_inv_mc(input logic [31:0] w);
        logic [7:0]  a [4];
        logic [7:0]  coef [4];
        logic [7:0]  o;
        logic [31:0] r;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        for (int k = 0; k < 4; k++) a[k] = w[8*(3-k) +: 8];
        r = '0;
        for (int rr = 0; rr < 4; rr++) begin
            o = 8'h00;
            for (int c = 0; c < 4; c++) o = o ^ gmul(coef[(c - rr + 4) % 4], a[c]);
            r[8*(3-rr) +: 8] = o;
        end
        return r;
    endfunction

    // Share words (share i at [32i +: 32]) -> DUT interleaved layout
    function automatic logic [W-1:0] pack(input logic [W-1:0] sw);
        logic [W-1:0] p;
        p = '0;
        for (int i = 0; i < D; i++)
            for (int k = 0; k < 4; k++)
                for (int j = 0; j < 8; j++)
                    p[8*D*k + D*j + i] = sw[32*i + 8*(3-k) + j];
        return p;
    endfunction

    function automatic logic [W-1:0] unpack(input logic [W-1:0] p);
        logic [W-1:0] sw;
        sw = '0;
        for (int i = 0; i < D; i++)
            for (int k = 0; k < 4; k++)
                for (int j = 0; j < 8; j++)
                    sw[32*i + 8*(3-k) + j] = p[8*D*k + D*j + i];
        return sw;
    endfunction

    function automatic logic [W-1:0] ref_col(input logic [W-1:0] packed_in);
        logic [W-1:0] sw;
        logic [W-1:0] r;
        sw = unpack(packed_in);
        r = '0;
        for (int i = 0; i < D; i++) r[32*i +: 32] = ref_inv_mc(sw[32*i +: 32]);
        return pack(r);
    endfunction

    function automatic logic [31:0] unmask(input logic [W-1:0] p);
        logic [W-1:0] sw;
        logic [31:0]  x;
        sw = unpack(p);
        x = '0;
        for (int i = 0; i < D; i++) x = x ^ sw[32*i +: 32];
        return x;
    endfunction

    function automatic logic [W-1:0] rand_shares();
        logic [W-1:0] sw;
        for (int i = 0; i < D; i++) sw[32*i +: 32] = $urandom;
        return sw;
    endfunction

    // Share 0 = v ^ mask, share 1 = mask
    function automatic logic [W-1:0] mask_word(input logic [31:0] v, input logic [31:0] m);
        logic [W-1:0] sw;
        sw = '0;
        sw[31:0]  = v ^ m;
        sw[63:32] = m;
        return sw;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: push on accepted input, pop/compare on delivered output
    initial begin
        logic         prev_stall;
        logic [W-1:0] prev_col;
        logic         prev_last;
        exp_t         e;
        prev_stall = 1'b0;
        prev_col = '0;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_col", out_col, prev_col);
                    check("stall_last", out_last, prev_last);
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        check("unexpected_out", out_col, '0);
                        if (out_col === '0) begin
                            bad++;
                            $display("FAIL unexpected_out: got output with empty scoreboard, required none");
                        end
                    end else begin
                        e = q.pop_front();
                        check("out_col", out_col, e.col);
                        check("out_last", out_last, e.last);
                        if (e.has_gold) check("unmasked", unmask(out_col), e.gold);
                        if (e.chk_lat) check("latency", cyc - e.cyc, LAT);
                        out_cyc_q.push_back(cyc);
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_col = out_col;
                prev_last = out_last;
                if (in_valid && in_ready) begin
                    e.col = ref_col(in_col);
                    e.last = (idx == 3);
                    e.has_gold = cur_has_gold;
                    e.gold = cur_gold;
                    e.chk_lat = cur_chk_lat;
                    e.cyc = cyc;
                    q.push_back(e);
                    idx = (idx + 1) % 4;
                    push_cnt++;
                end
            end
        end
    end

    // Present one column and hold it until accepted (called at posedge+1)
    task automatic send(input logic [W-1:0] sw, input logic hg, input logic [31:0] g, input logic cl);
        int n;
        int start;
        in_col = pack(sw);
        in_valid = 1'b1;
        cur_has_gold = hg;
        cur_gold = g;
        cur_chk_lat = cl;
        start = push_cnt;
        n = 0;
        while (push_cnt == start && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (push_cnt == start) begin
            bad++;
            total++;
            $display("FAIL send_timeout: got no acceptance after %0d cycles, required acceptance", n);
        end
        send_waits += n;
        in_valid = 1'b0;
        cur_has_gold = 1'b0;
        cur_chk_lat = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] m;
        logic [W-1:0] sw;
        int last_push;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_col = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_col", out_col, 0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", in_ready, 1);

        // Four back-to-back columns, one per cycle, last on the 4th
        out_ready = 1'b1;
        send_waits = 0;
        m = $urandom; send(mask_word(32'h01010101, m), 1'b1, 32'h01010101, 1'b1);
        m = $urandom; send(mask_word(32'hc6c6c6c6, m), 1'b1, 32'hc6c6c6c6, 1'b0);
        m = $urandom; send(mask_word(32'h8e4da1bc, m), 1'b1, 32'hdb135345, 1'b0);
        m = $urandom; send(mask_word(32'h9fdc589d, m), 1'b1, 32'hf20a225c, 1'b0);
        check("b2b_in_waits", send_waits, 4);
        drain();
        n = out_cyc_q.size();
        if (n >= 4) check("b2b_out_gap", out_cyc_q[n-1] - out_cyc_q[n-4], 3);
        else check("b2b_out_count", n, 4);

        // Single column, share1 = 0
        send({32'h0, 32'h8e4da1bc}, 1'b1, 32'hdb135345, 1'b1);
        drain();

        // Random mask, each share checked sharewise by the scoreboard
        m = $urandom;
        send({m ^ 32'h9fdc589d, m}, 1'b1, 32'hf20a225c, 1'b1);
        drain();

        // Fill the pipeline with out_ready low and hold for 3 cycles
        out_ready = 1'b0;
        for (int i = 0; i < LAT; i++) send(rand_shares(), 1'b0, '0, 1'b0);
        sw = rand_shares();
        in_col = pack(sw);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_in_ready", in_ready, 0);
            check("full_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(sw, 1'b0, '0, 1'b0);
        drain();

        // Asynchronous reset after two accepted columns
        send(rand_shares(), 1'b0, '0, 1'b0);
        send(rand_shares(), 1'b0, '0, 1'b0);
        out_ready = 1'b0;
        #1 check("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_last", out_last, 0);
        check("async_rst_col", out_col, 0);
        q.delete();
        idx = 0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 check("ready_after_rst2", in_ready, 1);
        for (int i = 0; i < 4; i++) send(rand_shares(), 1'b0, '0, 1'b0);
        drain();

        // Random valid/ready traffic
        last_push = push_cnt;
        for (int c = 0; c < 8000; c++) begin
            @(posedge clk);
            #1;
            if (!in_valid || push_cnt != last_push) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_col = pack(rand_shares());
            end
            last_push = push_cnt;
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        check("random_count_min", push_cnt > 1000, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
